// File: rtl/bti_arb2_pkg.sv
// Shared BTI arbiter definitions: FSM state encoding and host count.
package bti_arb2_pkg;

    localparam int BTI_ARB_HOST_NUM = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } bti_arb_st_e;

endpackage

// File: rtl/bti_arb_pick.sv
// Two-host arbitration decision, purely combinational.
// When both hosts request, the host named by ptr wins; a constant ptr of 0
// therefore degenerates into fixed priority for host 0.
module bti_arb_pick
    import bti_arb2_pkg::*;
(
    input  logic [BTI_ARB_HOST_NUM-1:0] req,
    input  logic                        ptr,
    output logic                        winner,
    output logic                        any
);

    // Pick the preferred host on a tie, otherwise whichever host is requesting.
    always_comb begin
        any    = |req;
        winner = 1'b0;
        if (req[0] && req[1]) begin
            winner = ptr;
        end else if (req[1]) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/bti_arb2.sv
// Two-host to one-guest BTI arbiter with a single outstanding transaction.
// Optional build macro BTI_ARB2_RR_EN: round-robin between hosts on ties;
// when undefined, host 0 always wins ties and no pointer register exists.
module bti_arb2
    import bti_arb2_pkg::*;
#(
    parameter int BTI_AW = 32,
    parameter int BTI_DW = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              h0_req_vld,
    output logic              h0_req_rdy,
    input  logic [BTI_AW-1:0] h0_req_addr,
    input  logic              h0_req_wr,
    input  logic [BTI_DW-1:0] h0_req_wdata,
    output logic              h0_rsp_vld,
    input  logic              h0_rsp_rdy,
    output logic [BTI_DW-1:0] h0_rsp_rdata,

    input  logic              h1_req_vld,
    output logic              h1_req_rdy,
    input  logic [BTI_AW-1:0] h1_req_addr,
    input  logic              h1_req_wr,
    input  logic [BTI_DW-1:0] h1_req_wdata,
    output logic              h1_rsp_vld,
    input  logic              h1_rsp_rdy,
    output logic [BTI_DW-1:0] h1_rsp_rdata,

    output logic              g_req_vld,
    input  logic              g_req_rdy,
    output logic [BTI_AW-1:0] g_req_addr,
    output logic              g_req_wr,
    output logic [BTI_DW-1:0] g_req_wdata,
    input  logic              g_rsp_vld,
    output logic              g_rsp_rdy,
    input  logic [BTI_DW-1:0] g_rsp_rdata,

    output logic              gnt_id,
    output logic              busy
);

    bti_arb_st_e state;
    bti_arb_st_e state_nxt;
    logic        pick_ptr;
    logic        pick_winner;
    logic        pick_any;
    logic        req_done;
    logic        rsp_done;

    assign req_done = (state == REQ) && g_req_vld && g_req_rdy;
    assign rsp_done = (state == RSP) && g_rsp_vld && g_rsp_rdy;

    bti_arb_pick u_pick (
        .req    ({h1_req_vld, h0_req_vld}),
        .ptr    (pick_ptr),
        .winner (pick_winner),
        .any    (pick_any)
    );

`ifdef BTI_ARB2_RR_EN
    logic rr_ptr;

    // Prefer the host not served last; updated as each response completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (rsp_done) begin
            rr_ptr <= ~gnt_id;
        end
    end

    assign pick_ptr = rr_ptr;
`else
    assign pick_ptr = 1'b0;
`endif

    // State register and grant latch; the grant is captured only in IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            gnt_id <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_any) begin
                gnt_id <= pick_winner;
            end
        end
    end

    // Next-state logic: grant, wait for guest accept, wait for guest response.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_any) state_nxt = REQ;
            REQ:     if (req_done) state_nxt = RSP;
            RSP:     if (rsp_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Steer the granted host onto the guest; every handshake is gated by state.
    always_comb begin
        g_req_addr   = gnt_id ? h1_req_addr  : h0_req_addr;
        g_req_wr     = gnt_id ? h1_req_wr    : h0_req_wr;
        g_req_wdata  = gnt_id ? h1_req_wdata : h0_req_wdata;
        h0_rsp_rdata = g_rsp_rdata;
        h1_rsp_rdata = g_rsp_rdata;
        g_req_vld    = 1'b0;
        h0_req_rdy   = 1'b0;
        h1_req_rdy   = 1'b0;
        g_rsp_rdy    = 1'b0;
        h0_rsp_vld   = 1'b0;
        h1_rsp_vld   = 1'b0;
        busy         = (state != IDLE);
        case (state)
            REQ: begin
                g_req_vld  = gnt_id ? h1_req_vld : h0_req_vld;
                h0_req_rdy = !gnt_id && g_req_rdy;
                h1_req_rdy = gnt_id && g_req_rdy;
            end
            RSP: begin
                g_rsp_rdy  = gnt_id ? h1_rsp_rdy : h0_rsp_rdy;
                h0_rsp_vld = !gnt_id && g_rsp_vld;
                h1_rsp_vld = gnt_id && g_rsp_vld;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/bti_arb2.md
BTI_ARB2 -- requirements
Module: bti_arb2

Interface
REQ-001 Parameter BTI_AW, default 32, BTI address width SHALL be this value.
REQ-002 Parameter BTI_DW, default 32, BTI data width SHALL be this value.
REQ-003 Port clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  in  1  reset; it SHALL be synchronous and active-low.
REQ-005 Ports hN_req_vld in 1 / hN_req_rdy out 1 / hN_req_addr in BTI_AW / hN_req_wr in 1 / hN_req_wdata in BTI_DW (N=0,1) SHALL form the host-N request channel.
REQ-006 Ports hN_rsp_vld out 1 / hN_rsp_rdy in 1 / hN_rsp_rdata out BTI_DW (N=0,1) SHALL form the host-N response channel.
REQ-007 Ports g_req_vld out 1 / g_req_rdy in 1 / g_req_addr out BTI_AW / g_req_wr out 1 / g_req_wdata out BTI_DW SHALL form the guest request channel.
REQ-008 Ports g_rsp_vld in 1 / g_rsp_rdy out 1 / g_rsp_rdata in BTI_DW SHALL form the guest response channel.
REQ-009 Port gnt_id  out  1  host currently owning the guest; valid when busy=1.
REQ-010 Port busy  out  1  high in states REQ and RSP.

Function
REQ-011 Every accepted request (read or write) SHALL produce exactly one guest response; at most one transaction SHALL be outstanding.
REQ-012 FSM states SHALL be IDLE, REQ, RSP.
REQ-013 IDLE: if any hN_req_vld=1, the winner SHALL be registered into gnt_id and the FSM SHALL move to REQ next cycle; no handshake occurs in IDLE (all hN_req_rdy=0).
REQ-014 REQ: g_req_* SHALL equal the granted host's request fields combinationally; h[gnt]_req_rdy SHALL equal g_req_rdy; the other host's req_rdy SHALL be 0.
REQ-015 REQ -> RSP on g_req_vld & g_req_rdy.
REQ-016 RSP: h[gnt]_rsp_vld=g_rsp_vld, h[gnt]_rsp_rdata=g_rsp_rdata, g_rsp_rdy=h[gnt]_rsp_rdy; other host rsp_vld=0.
REQ-017 RSP -> IDLE on g_rsp_vld & g_rsp_rdy; round-robin pointer SHALL update in the same cycle.
REQ-018 Outside REQ, g_req_vld SHALL be 0; outside RSP, g_rsp_rdy and all hN_rsp_vld SHALL be 0.
REQ-019 Minimum transaction latency: request accepted 1 cycle after host asserts vld (guest rdy=1); back-to-back transactions SHALL occupy >=3 cycles each.
REQ-020 Host dropping req_vld while in REQ is a protocol violation; behaviour is undefined (assertion in bench).
REQ-021 Guest response arriving while in REQ SHALL be ignored (g_rsp_rdy=0).

Reset
REQ-022 On rst_n=0 at a clock edge: state=IDLE, gnt_id=0, busy=0, RR pointer=0 (host 0 preferred), all vld/rdy outputs=0, including mid-transaction; any in-flight guest response is dropped.

Configuration
REQ-023 Macro BTI_ARB2_RR_EN defined: round-robin; the host not most recently served SHALL win when both request.
REQ-024 Macro BTI_ARB2_RR_EN undefined: fixed priority, host 0 SHALL always win ties; RR pointer register SHALL not exist.

Structure
REQ-025 FSM state enum (bti_arb_st_e) and host count constant BTI_ARB_HOST_NUM=2 SHALL live in the shared BTI package.
REQ-026 Arbitration decision SHALL be one sub-module, bti_arb_pick (requests, pointer -> winner), purely combinational; FSM and muxing stay in bti_arb2.

Verification
REQ-027 Single read: h0 addr=0x1000_0004, g_req_rdy=1, guest returns 0xDEAD_BEEF after 2 cycles -> h0_rsp_rdata=0xDEAD_BEEF, h1 sees no vld, busy falls the cycle after rsp handshake.
REQ-028 Both hosts request continuously, RR_EN defined -> grants alternate 0,1,0,1 over 4 transactions; RR_EN undefined -> 4 grants all to h0.
REQ-029 Backpressure: g_req_rdy=0 for 5 cycles -> g_req_* stable, h0_req_rdy=0 throughout, FSM stays REQ; then accept.
REQ-030 Response stall: h1_rsp_rdy=0 for 3 cycles with g_rsp_vld=1 -> g_rsp_rdy=0, FSM stays RSP, h0 request not granted until completion.
REQ-031 Reset mid-RSP: assert rst_n=0 one cycle -> next cycle state IDLE, busy=0, gnt_id=0, all vld outputs 0; new h1 write completes normally afterwards.
REQ-032 Write with data 0x0000_00A5 to 0x3000_0000 from h1 -> g_req_wr=1, g_req_wdata=0x0000_00A5, one response returned to h1.
